// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package ssd_pkg;

    localparam int unsigned SEG_W = 8;

    // Active-low blank pattern: every segment and the decimal point off
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    // Bit positions inside a segment pattern
    localparam int unsigned SEG_A  = 7;
    localparam int unsigned SEG_B  = 6;
    localparam int unsigned SEG_C  = 5;
    localparam int unsigned SEG_D  = 4;
    localparam int unsigned SEG_E  = 3;
    localparam int unsigned SEG_F  = 2;
    localparam int unsigned SEG_G  = 1;
    localparam int unsigned SEG_DP = 0;

    // Phase within one digit slot
    typedef enum logic {
        PH_GUARD = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

endpackage

// File: rtl/ssd_scan_timer.sv
// Slot prescaler and digit index for the multiplexed display scan.
module ssd_scan_timer
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned GUARD_CYCLES = 2,
    localparam int unsigned CNT_W = $clog2(SCAN_DIV),
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] idx,
    output phase_t           phase,
    output logic             slot_end,
    output logic             frame_end
);

    // Slot and frame boundaries decoded from the current position
    assign slot_end  = (cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
    assign phase     = (cnt < CNT_W'(GUARD_CYCLES)) ? PH_GUARD : PH_DRIVE;

    // Cycle counter within a slot; advance the digit index at each slot end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= frame_end ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Double-buffered, time-multiplexed seven-segment display driver with guard blanking.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    output logic [NUM_DIGITS-1:0]       ssd_ctl,
    output logic [SEG_W-1:0]            ssd_seg,
    output logic                        frame_tick
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    phase_t           phase;
    logic             slot_end;
    logic             frame_end;

    // Packed per-digit view: element i is the pattern of digit i
    logic [NUM_DIGITS-1:0][SEG_W-1:0] pending_buf;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] active_buf;

    logic                  accept;
    logic [NUM_DIGITS-1:0] ctl_d;
    logic [SEG_W-1:0]      seg_d;

    ssd_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt       (cnt),
        .idx       (idx),
        .phase     (phase),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    // in_ready doubles as the "pending buffer empty" flag
    assign accept = in_valid && in_ready;

    // Capture into pending; promote pending to active only at a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_buf <= {NUM_DIGITS{SEG_BLANK}};
            active_buf  <= {NUM_DIGITS{SEG_BLANK}};
            in_ready    <= 1'b1;
        end else if (accept) begin
            pending_buf <= seg_in;
            in_ready    <= 1'b0;
        end else if (frame_end && !in_ready) begin
            active_buf <= pending_buf;
            in_ready   <= 1'b1;
        end
    end

    // Next anode/segment values for the current slot position
    always_comb begin
        ctl_d = '1;
        seg_d = SEG_BLANK;
        if (phase == PH_DRIVE && digit_en[idx]) begin
            ctl_d[idx] = 1'b0;
            seg_d      = active_buf[idx];
        end
    end

    // Output registers, one cycle behind the scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssd_ctl    <= '1;
            ssd_seg    <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            ssd_ctl    <= ctl_d;
            ssd_seg    <= seg_d;
            frame_tick <= frame_end;
        end
    end

    // A frame boundary is always the last cycle of a slot
    frame_end_in_slot_end: assert property (
        @(posedge clk) disable iff (!rst_n)
        frame_end |-> (slot_end && cnt == CNT_W'(SCAN_DIV - 1))
    );

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomized and directed bench for ssd_scan_ctrl against a frame-level reference model.
module tb_ssd_scan_ctrl;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = ND * DIV;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [8*ND-1:0] seg_in;
    logic          in_valid;
    logic          in_ready;
    logic [ND-1:0] digit_en;
    logic [ND-1:0] ssd_ctl;
    logic [7:0]    ssd_seg;
    logic          frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: cycles since reset release, buffers, ready flag
    int         t;
    logic [7:0] act  [ND];
    logic [7:0] pend [ND];
    bit         m_ready;

    ssd_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (DIV),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .digit_en   (digit_en),
        .ssd_ctl    (ssd_ctl),
        .ssd_seg    (ssd_seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d time=%0t got=%h exp=%h", tag, t, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_ready = 1'b1;
        for (int i = 0; i < ND; i++) begin
            act[i]  = 8'hFF;
            pend[i] = 8'hFF;
        end
    endtask

    // Advance one clock: predict this cycle's registered outputs, then compare after the edge
    task automatic step();
        int         pos;
        int         dig;
        logic [3:0] e_ctl;
        logic [7:0] e_seg;
        bit         bnd;
        pos   = t % DIV;
        dig   = (t / DIV) % ND;
        e_ctl = 4'hF;
        e_seg = 8'hFF;
        if (pos >= GUARD && digit_en[dig]) begin
            e_ctl[dig] = 1'b0;
            e_seg      = act[dig];
        end
        bnd = ((t % FRAME) == FRAME - 1);
        if (in_valid && m_ready) begin
            for (int i = 0; i < ND; i++) pend[i] = seg_in[8*i +: 8];
            m_ready = 1'b0;
        end else if (bnd && !m_ready) begin
            for (int i = 0; i < ND; i++) act[i] = pend[i];
            m_ready = 1'b1;
        end
        t++;
        @(posedge clk);
        #1;
        check("ssd_ctl", 32'(ssd_ctl), 32'(e_ctl));
        check("ssd_seg", 32'(ssd_seg), 32'(e_seg));
        check("frame_tick", 32'(frame_tick), 32'(bnd));
        check("in_ready", 32'(in_ready), 32'(m_ready));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        seg_in   = '0;
        digit_en = 4'hF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", 32'(ssd_ctl), 32'hF);
        check("rst_seg", 32'(ssd_seg), 32'hFF);
        check("rst_tick", 32'(frame_tick), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;

        // Idle after reset: blank display, first tick after one full frame
        run(40);

        // Single frame accepted, shown from the next frame on
        seg_in   = {8'h9F, 8'h25, 8'h0D, 8'h03};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        run(80);

        // Held valid with a second frame: captured only once pending empties
        seg_in   = {8'h12, 8'h34, 8'h56, 8'h78};
        in_valid = 1'b1;
        step();
        seg_in   = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run(70);
        in_valid = 1'b0;
        run(40);

        // Accept exactly in the boundary cycle
        for (int k = 0; k < 4 * FRAME && !(m_ready && (t % FRAME) == FRAME - 1); k++) step();
        check("bnd_ready", 32'(in_ready), 32'h1);
        seg_in   = {8'h01, 8'h4F, 8'h12, 8'h06};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        run(80);

        // Partial digit enable
        digit_en = 4'b1010;
        run(40);
        digit_en = 4'hF;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(3) == 0);
            seg_in   = $urandom;
            if ($urandom_range(19) == 0) digit_en = 4'($urandom);
            step();
        end
        in_valid = 1'b0;
        digit_en = 4'hF;

        // Async reset during slot 2 drive with a pending frame held
        for (int k = 0; k < 4 * FRAME && !(m_ready && (t % FRAME) == 0); k++) step();
        seg_in   = {8'h24, 8'h30, 8'h19, 8'h79};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < FRAME && (t % FRAME) != 2 * DIV + 4; k++) step();
        check("pre_rst_ready", 32'(in_ready), 32'h0);
        check("pre_rst_ctl", 32'(ssd_ctl), 32'hB);
        rst_n = 1'b0;
        #1;
        check("arst_ctl", 32'(ssd_ctl), 32'hF);
        check("arst_seg", 32'(ssd_seg), 32'hFF);
        check("arst_tick", 32'(frame_tick), 32'h0);
        check("arst_ready", 32'(in_ready), 32'h1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
